// File: rtl/frame_tx_pkg.sv
// Shared types and default sizing for the serial frame transmitter.
package frame_tx_pkg;

    localparam int LEN_W_DEF     = 4;
    localparam int PARITY_EN_DEF = 1;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PARITY  = 2'd3
    } state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Loadable down-counter with a zero flag; paces the length field and the payload.
module tx_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/frame_transmitter.sv
// Receives a length-prefixed serial frame on RcIn and retransmits the payload
// (plus optional even parity) on txOut with one cycle of latency.
module frame_transmitter
    import frame_tx_pkg::*;
#(
    parameter int LEN_W     = LEN_W_DEF,
    parameter int PARITY_EN = PARITY_EN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RcIn,
    input  logic             start,
    input  logic             abort,
    output logic             txOut,
    output logic             txValid,
    output logic             txAbort,
    output logic             startSeen,
    output logic             txDone,
    output logic             busy,
    output logic [CNT_W-1:0] frameCount
);

    state_t             state_d, state_q;
    logic [LEN_W-1:0]   len_d, len_q, len_shift;
    logic               par_d, par_q;
    logic               tx_out_d, tx_out_q;
    logic               tx_valid_d, tx_valid_q;
    logic               tx_abort_d, tx_abort_q;
    logic               start_seen_d, start_seen_q;
    logic               tx_done_d, tx_done_q;
    logic               busy_d, busy_q;
    logic [CNT_W-1:0]   count_d, count_q;

    logic               cnt_load, cnt_dec, cnt_zero, end_body;
    logic [LEN_W-1:0]   cnt_load_val;

    tx_bit_counter #(.W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        par_d        = par_q;
        tx_out_d     = 1'b0;
        tx_valid_d   = 1'b0;
        tx_abort_d   = 1'b0;
        start_seen_d = 1'b0;
        tx_done_d    = 1'b0;
        count_d      = count_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        end_body     = 1'b0;
        len_shift    = LEN_W'({len_q, RcIn});

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LEN;
                    start_seen_d = 1'b1;
                    len_d        = '0;
                    par_d        = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = LEN_W'(LEN_W - 1);
                end
            end
            ST_LEN: begin
                len_d = len_shift;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (len_shift != '0) begin
                    state_d      = ST_PAYLOAD;
                    cnt_load     = 1'b1;
                    cnt_load_val = len_shift;
                end else begin
                    end_body = 1'b1;
                end
            end
            // Counter holds the bits still to sample; the extra cycle at zero
            // is the one where the last payload bit is on the wire.
            ST_PAYLOAD: begin
                if (!cnt_zero) begin
                    tx_out_d   = RcIn;
                    tx_valid_d = 1'b1;
                    par_d      = par_q ^ RcIn;
                    cnt_dec    = 1'b1;
                end else begin
                    end_body = 1'b1;
                end
            end
            ST_PARITY: begin
                state_d   = ST_IDLE;
                tx_done_d = 1'b1;
                count_d   = count_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (end_body) begin
            if (PARITY_EN != 0) begin
                state_d    = ST_PARITY;
                tx_out_d   = par_q;
                tx_valid_d = 1'b1;
            end else begin
                state_d   = ST_IDLE;
                tx_done_d = 1'b1;
                count_d   = count_q + 1'b1;
            end
        end

        // Abort beats everything, including a completion on the same edge.
        if (abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            tx_out_d     = 1'b0;
            tx_valid_d   = 1'b0;
            tx_done_d    = 1'b0;
            start_seen_d = 1'b0;
            tx_abort_d   = 1'b1;
            count_d      = count_q;
            cnt_load     = 1'b0;
            cnt_dec      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            par_q        <= 1'b0;
            tx_out_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_abort_q   <= 1'b0;
            start_seen_q <= 1'b0;
            tx_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            par_q        <= par_d;
            tx_out_q     <= tx_out_d;
            tx_valid_q   <= tx_valid_d;
            tx_abort_q   <= tx_abort_d;
            start_seen_q <= start_seen_d;
            tx_done_q    <= tx_done_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
        end
    end

    assign txOut      = tx_out_q;
    assign txValid    = tx_valid_q;
    assign txAbort    = tx_abort_q;
    assign startSeen  = start_seen_q;
    assign txDone     = tx_done_q;
    assign busy       = busy_q;
    assign frameCount = count_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Bench: three DUT variants share one stimulus stream; a timeline model of
// expected outputs per edge is checked every cycle, plus literal pins.
module tb_frame_transmitter;

    localparam int L    = 4;
    localparam int MAXE = 1024;
    localparam int NV   = 3;   // 0: parity, CNT_W=8   1: no parity   2: parity, CNT_W=2

    logic clk = 1'b0, rst = 1'b1, RcIn = 1'b0, start = 1'b0, abort = 1'b0;
    always #5 clk = ~clk;

    logic [NV-1:0] o_out, o_val, o_ab, o_ss, o_dn, o_bz;
    logic [7:0] fc0, fc1;
    logic [1:0] fc2;

    frame_transmitter #(.LEN_W(4), .PARITY_EN(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .RcIn(RcIn), .start(start), .abort(abort),
        .txOut(o_out[0]), .txValid(o_val[0]), .txAbort(o_ab[0]), .startSeen(o_ss[0]),
        .txDone(o_dn[0]), .busy(o_bz[0]), .frameCount(fc0));
    frame_transmitter #(.LEN_W(4), .PARITY_EN(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .RcIn(RcIn), .start(start), .abort(abort),
        .txOut(o_out[1]), .txValid(o_val[1]), .txAbort(o_ab[1]), .startSeen(o_ss[1]),
        .txDone(o_dn[1]), .busy(o_bz[1]), .frameCount(fc1));
    frame_transmitter #(.LEN_W(4), .PARITY_EN(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .RcIn(RcIn), .start(start), .abort(abort),
        .txOut(o_out[2]), .txValid(o_val[2]), .txAbort(o_ab[2]), .startSeen(o_ss[2]),
        .txDone(o_dn[2]), .busy(o_bz[2]), .frameCount(fc2));

    // Expected value of every output as registered at each edge.
    bit e_ss[NV][MAXE], e_v[NV][MAXE], e_o[NV][MAXE], e_d[NV][MAXE], e_ab[NV][MAXE], e_b[NV][MAXE];
    bit e_rst[MAXE];
    bit ob_v[NV][MAXE], ob_o[NV][MAXE], ob_d[NV][MAXE], ob_a[NV][MAXE];
    int mcnt[NV];

    int nedge = 0;
    int n_vec = 0, n_bad = 0;

    always @(posedge clk) nedge <= nedge + 1;

    function automatic int en_of(input int v);
        return (v == 1) ? 0 : 1;
    endfunction

    function automatic int cw_of(input int v);
        return (v == 2) ? 2 : 8;
    endfunction

    function automatic logic [7:0] fc_of(input int v);
        if (v == 0) return fc0;
        if (v == 1) return fc1;
        return {6'b0, fc2};
    endfunction

    function automatic void chk(input string nm, input int v, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, v, nedge - 1, act, exp);
        end
    endfunction

    task automatic clr(input int v, input int a, input int b);
        for (int e = a; e <= b && e < MAXE; e++) begin
            e_ss[v][e] = 0; e_v[v][e] = 0; e_o[v][e] = 0;
            e_d[v][e]  = 0; e_ab[v][e] = 0; e_b[v][e] = 0;
        end
    endtask

    // Frame started at edge k with n payload bits; abort sampled at edge ab (or -1).
    task automatic sched(input int k, input int n, input logic [15:0] pay, input int ab);
        for (int v = 0; v < NV; v++) begin
            int tail, de;
            bit par;
            tail = (n > 0) ? k + L + n + 1 : k + L;
            de   = (en_of(v) != 0) ? tail + 1 : tail;
            par  = 0;
            e_ss[v][k] = 1;
            for (int e = k; e < de; e++) e_b[v][e] = 1;
            for (int i = 0; i < n; i++) begin
                e_v[v][k + L + 1 + i] = 1;
                e_o[v][k + L + 1 + i] = pay[i];
                par ^= pay[i];
            end
            if (en_of(v) != 0) begin
                e_v[v][tail] = 1;
                e_o[v][tail] = par;
            end
            e_d[v][de] = 1;
            if (ab > k && ab <= de) begin
                clr(v, ab, de);
                e_ab[v][ab] = 1;
            end
        end
    endtask

    task automatic step(input logic s, input logic a, input logic d, input logic r);
        if (r) begin
            e_rst[nedge] = 1;
            for (int v = 0; v < NV; v++) clr(v, nedge, nedge + 40);
        end
        start = s; abort = a; RcIn = d; rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic frame(input int n, input logic [15:0] pay, input int ab_off, input int st_off, input int rst_off);
        int k;
        k = nedge;
        sched(k, n, pay, (ab_off >= 0) ? k + ab_off : -1);
        for (int t = 0; t <= L + n + 3; t++) begin
            logic d;
            if (t >= 1 && t <= L)          d = n[L - t];
            else if (t > L && t <= L + n)  d = pay[t - L - 1];
            else                           d = 1'($urandom);
            step(t == 0 || t == st_off, t == ab_off, d, t == rst_off);
        end
    endtask

    task automatic scan(input int v, input int a, input int b, output int nb, output logic [31:0] bits,
                        output int dedge, output int aedge);
        nb = 0; bits = '0; dedge = -1; aedge = -1;
        for (int e = a; e <= b; e++) begin
            if (ob_v[v][e]) begin
                bits = {bits[30:0], ob_o[v][e]};
                nb++;
            end
            if (ob_d[v][e] && dedge < 0) dedge = e;
            if (ob_a[v][e] && aedge < 0) aedge = e;
        end
    endtask

    // Every-cycle compare against the timeline model.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (nedge > 0 && nedge <= MAXE) begin
                e = nedge - 1;
                for (int v = 0; v < NV; v++) begin
                    if (e_rst[e])       mcnt[v] = 0;
                    else if (e_d[v][e]) mcnt[v] = mcnt[v] + 1;
                    chk("txOut",      v, o_out[v], e_o[v][e]);
                    chk("txValid",    v, o_val[v], e_v[v][e]);
                    chk("txAbort",    v, o_ab[v],  e_ab[v][e]);
                    chk("startSeen",  v, o_ss[v],  e_ss[v][e]);
                    chk("txDone",     v, o_dn[v],  e_d[v][e]);
                    chk("busy",       v, o_bz[v],  e_b[v][e]);
                    chk("frameCount", v, fc_of(v), mcnt[v] % (1 << cw_of(v)));
                    ob_v[v][e] = o_val[v]; ob_o[v][e] = o_out[v];
                    ob_d[v][e] = o_dn[v];  ob_a[v][e] = o_ab[v];
                end
            end
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1);
    end

    initial begin
        int k, nb, de, ae;
        logic [31:0] bits;
        int exp_fc2[4] = '{1, 2, 3, 0};

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_busy", 0, o_bz[0], 0);
        chk("rst_valid", 0, o_val[0], 0);
        chk("rst_count", 0, fc0, 0);
        idle(2);

        // length 0101, payload 1,0,1,1,0 -> parity 1
        k = nedge;
        frame(5, 16'b0_1101, -1, -1, -1);
        idle(2);
        scan(0, k, k + 12, nb, bits, de, ae);
        chk("A_nbits", 0, nb, 6);
        chk("A_bits", 0, bits, 32'b101101);
        chk("A_done_ofs", 0, de - k, 11);
        chk("A_count", 0, fc0, 1);

        // zero-length frame
        k = nedge;
        frame(0, 16'h0, -1, -1, -1);
        idle(2);
        scan(0, k, k + 7, nb, bits, de, ae);
        chk("B_nbits", 0, nb, 1);
        chk("B_bits", 0, bits, 0);
        chk("B_done_ofs", 0, de - k, 5);
        scan(1, k, k + 7, nb, bits, de, ae);
        chk("B_nbits", 1, nb, 0);
        chk("B_done_ofs", 1, de - k, 4);

        // length 1111, abort on the 3rd payload edge
        k = nedge;
        frame(15, 16'h5A3C, 7, -1, -1);
        idle(2);
        scan(0, k, k + 22, nb, bits, de, ae);
        chk("C_nbits", 0, nb, 2);
        chk("C_done", 0, de, -1);
        chk("C_abort_ofs", 0, ae - k, 7);
        chk("C_count", 0, fc0, 2);
        chk("C_busy", 0, o_bz[0], 0);

        frame(6, 16'h002D, -1, 6, -1);                 // start mid-frame
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);                  // abort in IDLE
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("E_busy", 0, o_bz[0], 0);
        chk("E_abort", 0, o_ab[0], 0);

        k = nedge;
        frame(3, 16'b101, 0, -1, -1);                  // start+abort together
        idle(1);
        scan(0, k, k + 10, nb, bits, de, ae);
        chk("F_done_ofs", 0, de - k, 9);

        k = nedge;
        frame(4, 16'b0111, 9, -1, -1);                 // abort as parity is emitted
        idle(1);
        scan(0, k, k + 11, nb, bits, de, ae);
        chk("G1_nbits", 0, nb, 4);
        chk("G1_done", 0, de, -1);

        k = nedge;
        frame(4, 16'b1001, 10, -1, -1);                // abort while parity is shown
        idle(1);
        scan(0, k, k + 11, nb, bits, de, ae);
        chk("G2_bits", 0, bits, 32'b10010);
        chk("G2_done", 0, de, -1);

        for (int i = 0; i < 4; i++) begin
            frame(int'($urandom_range(1, 15)), 16'($urandom), -1, -1, -1);
            idle(1);
        end

        // reset mid-payload
        k = nedge;
        frame(8, 16'h00A5, -1, -1, 7);
        idle(1);
        scan(0, k, k + 13, nb, bits, de, ae);
        chk("H_valid_after_rst", 0, ob_v[0][k + 7], 0);
        chk("H_done", 0, de, -1);
        chk("H_abort", 0, ae, -1);
        chk("H_count", 0, fc0, 0);

        for (int i = 0; i < 4; i++) begin
            frame(1 + (i % 3), 16'($urandom), -1, -1, -1);
            chk("I_count_wrap", 2, fc2, exp_fc2[i]);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_transmitter.md
FRAME_TRANSMITTER -- requirements
Module: frame_transmitter

Interface
REQ-001 Parameter LEN_W, default 4: width of the serial length field; payload holds 0..2^LEN_W-1 bits.
REQ-002 Parameter PARITY_EN, default 1: 1 appends an even-parity bit after the payload, 0 omits it.
REQ-003 Parameter CNT_W, default 8: width of the completed-frame counter.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 RcIn  input  1  serial input; length field first (MSB first), then payload bits.
REQ-008 start  input  1  frame-start request, sampled in IDLE only.
REQ-009 abort  input  1  frame cancel, sampled in any non-IDLE state.
REQ-010 txOut  output  1  transmitted bit; 0 whenever txValid=0.
REQ-011 txValid  output  1  txOut carries a payload or parity bit.
REQ-012 txAbort  output  1  one-cycle pulse: frame aborted.
REQ-013 startSeen  output  1  one-cycle pulse: start accepted.
REQ-014 txDone  output  1  one-cycle pulse: frame completed.
REQ-015 busy  output  1  high while state is not IDLE.
REQ-016 frameCount  output  CNT_W  number of completed frames, modulo 2^CNT_W.

Function
REQ-017 All outputs shall be registered.
REQ-018 FSM states: IDLE, LEN, PAYLOAD, PARITY.
- IDLE -> LEN when start=1.
- LEN -> PAYLOAD after LEN_W bits when N>0.
- PAYLOAD -> PARITY (PARITY_EN=1) or IDLE (PARITY_EN=0) after N bits.
- PARITY -> IDLE after 1 cycle.
REQ-019 Start: start=1 at edge k in IDLE sets startSeen=1 and busy=1 from cycle k+1; the length bits are sampled at edges k+1..k+LEN_W.
REQ-020 Length: N is shifted in MSB first; N=0 goes straight to PARITY (PARITY_EN=1) or IDLE with txDone (PARITY_EN=0).
REQ-021 Payload: each bit sampled at edge j appears on txOut with txValid=1 during cycle j+1 (1-cycle latency); exactly N valid cycles, back-to-back.
REQ-022 Parity: the parity bit is the XOR of all N payload bits (0 when N=0), driven with txValid=1 in the cycle after the last payload bit.
REQ-023 Completion: txDone=1 for one cycle, the cycle after the last valid bit (after the last length bit if no bits are sent); frameCount increments with it and busy falls with it.
REQ-024 Abort, any non-IDLE state:
- next cycle: txAbort=1, txValid=0, txOut=0, busy=0, state IDLE;
- frameCount unchanged, no txDone.
REQ-025 Abort on the same edge as the last payload or parity bit: abort wins; no txDone.
REQ-026 Abort in IDLE is ignored; start+abort together in IDLE: start is accepted.
REQ-027 start while busy is ignored; startSeen stays 0.
REQ-028 frameCount wraps from 2^CNT_W-1 to 0.

Reset
REQ-029 rst=1 at an edge forces state IDLE, clears every output to 0 and clears the length, bit counter and parity accumulator.
REQ-030 Reset mid-frame drops the frame silently: no txAbort, no txDone.

Structure
REQ-031 Package frame_tx_pkg shall hold the state enum and the default LEN_W/PARITY_EN/CNT_W constants.
REQ-032 Sub-module tx_bit_counter: loadable LEN_W-bit down-counter with a zero flag; it counts length bits and payload bits.

Verification
REQ-033 Reset: rst=1 for 2 cycles -> all outputs 0 and frameCount=0.
REQ-034 LEN_W=4, PARITY_EN=1: start, length 0101, payload 10110 -> startSeen 1 cycle; txOut 1,0,1,1,0 then parity 1, all with txValid=1; txDone next cycle; frameCount=1.
REQ-035 Length 0000:
- PARITY_EN=1: one valid cycle with txOut=0, then txDone.
- PARITY_EN=0: no valid cycles; txDone the cycle after the 4th length bit.
REQ-036 Length 1111, abort during the 3rd payload cycle -> txAbort 1 cycle, txValid=0 next cycle, busy=0, frameCount unchanged.
REQ-037 Ignore/priority rules:
- start mid-frame is ignored;
- abort in IDLE is ignored;
- start+abort together in IDLE starts a frame;
- abort on the parity edge gives no txDone.
REQ-038 CNT_W=2: 4 complete frames -> frameCount sequence 1,2,3,0; rst asserted mid-payload -> outputs 0 the next cycle.
